adc_sample_averager: RTL and testbench

ADC_SAMPLE_AVERAGER -- requirements
Module: adc_sample_averager

---
 rtl/adc_pkg.sv | 17 +
 rtl/sample_tick_gen.sv | 30 +++
 rtl/adc_sample_averager.sv | 160 ++++++++++++++++
 tb/tb_adc_sample_averager.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared FSM encoding, parameter defaults and datapath widths for the ADC sample averager.
package adc_pkg;

    localparam int SAMPLE_DIV_DEF  = 1000;
    localparam int LOG2_AVG_DEF    = 3;
    localparam int TIMEOUT_CYC_DEF = 4096;
    localparam int DIV_W           = 16;
    localparam int SAMPLE_W        = 16;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_DONE,
        ACCUM
    } adc_state_t;

endpackage

// File: rtl/sample_tick_gen.sv
// Purpose: free-running period counter, one-cycle tick at terminal count while enabled.
// Latency: tick is combinational from the counter; period is exactly i_divisor cycles.
// Backpressure: none; ticks are emitted regardless of downstream state.
module sample_tick_gen
    import adc_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic [DIV_W-1:0] i_divisor,
    output logic             o_tick
);

    logic [DIV_W-1:0] cnt;
    logic             at_term;

    assign at_term = (cnt == i_divisor - DIV_W'(1));
    assign o_tick  = i_enable && at_term;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (!i_enable || at_term) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/adc_sample_averager.sv
// Purpose: periodic ADC trigger, accumulate 2^LOG2_AVG samples, publish truncated mean.
// Latency: 2 cycles from the final sample's i_adc_done to o_avg_valid.
// Backpressure: valid/ready output; an unconsumed average is overwritten and flagged as overrun.
module adc_sample_averager
    import adc_pkg::*;
#(
    parameter int SAMPLE_DIV  = SAMPLE_DIV_DEF,
    parameter int LOG2_AVG    = LOG2_AVG_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_enable,
    output logic        o_adc_start,
    input  logic        i_adc_busy,
    input  logic        i_adc_done,
    input  logic [15:0] i_adc_data,
    output logic [15:0] o_avg_data,
    output logic        o_avg_valid,
    input  logic        i_avg_ready,
    output logic        o_overrun,
    output logic        o_timeout,
    input  logic        i_clear_flags
);

    localparam int ACC_W = SAMPLE_W + LOG2_AVG;
    localparam int CNT_W = LOG2_AVG + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [DIV_W-1:0] DIVISOR     = DIV_W'(SAMPLE_DIV);
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'((1 << LOG2_AVG) - 1);
    localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(TIMEOUT_CYC - 1);

    adc_state_t state, state_n;

    logic                tick;
    logic [TO_W-1:0]     wait_cnt;
    logic [SAMPLE_W-1:0] sample_q;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_sum;
    logic [CNT_W-1:0]    smp_cnt;
    logic                capture;
    logic                accum_en;
    logic                avg_load;
    logic                timeout_hit;
    logic                overrun_set;

    sample_tick_gen u_tick (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_enable  (i_enable),
        .i_divisor (DIVISOR),
        .o_tick    (tick)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        capture     = 1'b0;
        accum_en    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (tick && !i_adc_busy) begin
                    state_n = START;
                end
            end
            START: begin
                state_n = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (i_adc_done) begin
                    capture = 1'b1;
                    state_n = ACCUM;
                end else if (wait_cnt == TO_LAST) begin
                    timeout_hit = 1'b1;
                    state_n     = IDLE;
                end
            end
            ACCUM: begin
                accum_en = 1'b1;
                state_n  = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        // Disabling abandons the current average; a conversion already in flight is left to finish unheard.
        if (!i_enable) begin
            state_n  = IDLE;
            capture  = 1'b0;
            accum_en = 1'b0;
        end
    end

    assign o_adc_start = (state == START);
    assign acc_sum     = acc + ACC_W'(sample_q);
    assign avg_load    = accum_en && (smp_cnt == LAST_SAMPLE);
    assign overrun_set = (tick && ((state != IDLE) || i_adc_busy))
                       || (avg_load && o_avg_valid && !i_avg_ready);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wait_cnt    <= '0;
            sample_q    <= '0;
            acc         <= '0;
            smp_cnt     <= '0;
            o_avg_data  <= '0;
            o_avg_valid <= 1'b0;
            o_overrun   <= 1'b0;
            o_timeout   <= 1'b0;
        end else begin
            if (state == WAIT_DONE) begin
                wait_cnt <= wait_cnt + TO_W'(1);
            end else begin
                wait_cnt <= '0;
            end

            if (capture) begin
                sample_q <= i_adc_data;
            end

            if (!i_enable || avg_load) begin
                acc     <= '0;
                smp_cnt <= '0;
            end else if (accum_en) begin
                acc     <= acc_sum;
                smp_cnt <= smp_cnt + CNT_W'(1);
            end

            if (avg_load) begin
                o_avg_data  <= SAMPLE_W'(acc_sum >> LOG2_AVG);
                o_avg_valid <= 1'b1;
            end else if (i_avg_ready) begin
                o_avg_valid <= 1'b0;
            end

            // Setting a flag takes priority over a coincident clear.
            if (overrun_set) begin
                o_overrun <= 1'b1;
            end else if (i_clear_flags) begin
                o_overrun <= 1'b0;
            end

            if (timeout_hit) begin
                o_timeout <= 1'b1;
            end else if (i_clear_flags) begin
                o_timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc_sample_averager.sv
// Directed bench for adc_sample_averager: averaging table plus busy, timeout, overwrite and reset sequences.
module tb_adc_sample_averager;

    typedef struct {
        logic [15:0] base;
        logic [15:0] step;
        logic [15:0] exp_avg;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        enable0;
    logic        adc_busy;
    logic        adc_done;
    logic [15:0] adc_data;
    logic        avg_ready;
    logic        clear_flags;

    logic        adc_start,  adc_start0;
    logic [15:0] avg_data,   avg_data0;
    logic        avg_valid,  avg_valid0;
    logic        overrun,    overrun0;
    logic        timeout,    timeout0;

    logic        rd_busy, rd_done, busy_force, rd_hang, man_done;
    logic [15:0] rd_data, man_data, rd_base, rd_step;
    int          n_done, rd_mark;

    int          cyc;
    int          start_q[$];
    int          done_cyc, vcount, vcyc, v0count, v0cyc;
    logic [15:0] vdata, v0data;

    int   n_vec;
    int   n_fail;
    vec_t vecs[5];

    assign adc_busy = rd_busy | busy_force;
    assign adc_done = rd_done | man_done;
    assign adc_data = man_done ? man_data : rd_data;

    adc_sample_averager #(.SAMPLE_DIV(100), .LOG2_AVG(3), .TIMEOUT_CYC(50)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .o_adc_start(adc_start),
        .i_adc_busy(adc_busy), .i_adc_done(adc_done), .i_adc_data(adc_data),
        .o_avg_data(avg_data), .o_avg_valid(avg_valid), .i_avg_ready(avg_ready),
        .o_overrun(overrun), .o_timeout(timeout), .i_clear_flags(clear_flags)
    );

    adc_sample_averager #(.SAMPLE_DIV(64), .LOG2_AVG(0), .TIMEOUT_CYC(50)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable0), .o_adc_start(adc_start0),
        .i_adc_busy(adc_busy), .i_adc_done(adc_done), .i_adc_data(adc_data),
        .o_avg_data(avg_data0), .o_avg_valid(avg_valid0), .i_avg_ready(avg_ready),
        .o_overrun(overrun0), .o_timeout(timeout0), .i_clear_flags(clear_flags)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Reader model: busy from the cycle after start, done pulse two cycles later.
    initial begin
        rd_busy = 1'b0;
        rd_done = 1'b0;
        rd_data = 16'h0;
        n_done  = 0;
        forever begin
            @(posedge clk); #2;
            if ((adc_start || adc_start0) && !rd_hang) begin
                rd_busy = 1'b1;
                @(posedge clk); #2;
                @(posedge clk); #2;
                rd_data = rd_base + rd_step * 16'(n_done - rd_mark);
                n_done++;
                rd_done = 1'b1;
                @(posedge clk); #2;
                rd_done = 1'b0;
                rd_busy = 1'b0;
            end
        end
    end

    initial begin
        done_cyc = 0; vcount = 0; vcyc = 0; v0count = 0; v0cyc = 0;
        vdata = 16'h0; v0data = 16'h0;
        forever begin
            @(negedge clk);
            if (adc_start) start_q.push_back(cyc);
            if (adc_done) done_cyc = cyc;
            if (avg_valid && avg_ready) begin
                vcount++; vdata = avg_data; vcyc = cyc;
            end
            if (avg_valid0 && avg_ready) begin
                v0count++; v0data = avg_data0; v0cyc = cyc;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick1();
        @(posedge clk); #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic settle();
        enable      = 1'b0;
        enable0     = 1'b0;
        avg_ready   = 1'b1;
        repeat (8) tick1();
        clear_flags = 1'b1;
        tick1();
        clear_flags = 1'b0;
        repeat (2) tick1();
    endtask

    task automatic run_row(input int r);
        int k;
        int sq_mark;
        int v_mark;
        rd_base = vecs[r].base;
        rd_step = vecs[r].step;
        rd_mark = n_done;
        sq_mark = start_q.size();
        v_mark  = vcount;
        enable  = 1'b1;
        k = 0;
        while (vcount == v_mark && k < 1500) begin
            tick1();
            k++;
        end
        enable = 1'b0;
        check($sformatf("row%0d_wait", r), 32'(k < 1500), 1);
        check($sformatf("row%0d_avg", r), 32'(vdata), 32'(vecs[r].exp_avg));
        check($sformatf("row%0d_latency", r), vcyc - done_cyc, 2);
        check($sformatf("row%0d_starts", r), start_q.size() - sq_mark, 8);
        for (int i = sq_mark + 1; i < start_q.size(); i++) begin
            check($sformatf("row%0d_period%0d", r, i - sq_mark), start_q[i] - start_q[i-1], 100);
        end
        check($sformatf("row%0d_overrun", r), 32'(overrun), 0);
        settle();
    endtask

    initial begin
        int k;
        int sq_mark;
        int v_mark;
        n_vec = 0;
        n_fail = 0;
        vecs[0] = '{16'h1000, 16'h0001, 16'h1003};
        vecs[1] = '{16'hFFF8, 16'h0001, 16'hFFFB};
        vecs[2] = '{16'h0000, 16'h2000, 16'h7000};
        vecs[3] = '{16'hFFFF, 16'h0000, 16'hFFFF};
        vecs[4] = '{16'h0000, 16'h0001, 16'h0003};

        rst_n = 1'b0; enable = 1'b0; enable0 = 1'b0; avg_ready = 1'b1; clear_flags = 1'b0;
        busy_force = 1'b0; rd_hang = 1'b0; man_done = 1'b0; man_data = 16'h0;
        rd_base = 16'h0; rd_step = 16'h0; rd_mark = 0;
        repeat (3) tick1();
        check("rst_start", 32'(adc_start), 0);
        check("rst_data", 32'(avg_data), 0);
        check("rst_valid", 32'(avg_valid), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_valid0", 32'(avg_valid0), 0);
        rst_n = 1'b1;
        repeat (2) tick1();

        for (int r = 0; r < 5; r++) run_row(r);

        // Reader busy at every tick: no conversions, overrun sticky, set beats clear.
        busy_force = 1'b1;
        sq_mark = start_q.size();
        enable = 1'b1;
        k = 0;
        while (!overrun && k < 300) begin tick1(); k++; end
        check("busy_wait", 32'(k < 300), 1);
        tick1(); clear_flags = 1'b1;
        tick1(); clear_flags = 1'b0;
        check("busy_cleared", 32'(overrun), 0);
        repeat (97) tick1();
        clear_flags = 1'b1;
        tick1(); clear_flags = 1'b0;
        check("busy_set_wins", 32'(overrun), 1);
        check("busy_no_start", start_q.size() - sq_mark, 0);
        enable = 1'b0;
        busy_force = 1'b0;
        tick1(); clear_flags = 1'b1;
        tick1(); clear_flags = 1'b0;
        check("busy_clear_end", 32'(overrun), 0);
        settle();

        // Reader never completes: timeout after 50 WAIT_DONE cycles, next tick proceeds.
        rd_hang = 1'b1;
        sq_mark = start_q.size();
        enable = 1'b1;
        k = 0;
        while (!adc_start && k < 300) begin tick1(); k++; end
        check("to_start_wait", 32'(k < 300), 1);
        repeat (50) tick1();
        check("to_not_yet", 32'(timeout), 0);
        tick1();
        check("to_set", 32'(timeout), 1);
        rd_hang = 1'b0;
        k = 0;
        while (start_q.size() < sq_mark + 2 && k < 300) begin tick1(); k++; end
        check("to_restart_wait", 32'(k < 300), 1);
        if (start_q.size() >= sq_mark + 2)
            check("to_restart_period", start_q[sq_mark+1] - start_q[sq_mark], 100);
        check("to_no_overrun", 32'(overrun), 0);
        repeat (6) tick1();
        enable = 1'b0;
        tick1(); clear_flags = 1'b1;
        tick1(); clear_flags = 1'b0;
        check("to_cleared", 32'(timeout), 0);
        settle();

        // Two averages with no ready: second overwrites and flags overrun.
        avg_ready = 1'b0;
        rd_base = 16'h1000; rd_step = 16'h0001; rd_mark = n_done;
        v_mark = vcount;
        enable = 1'b1;
        k = 0;
        while (!avg_valid && k < 1200) begin tick1(); k++; end
        check("ovw_first_wait", 32'(k < 1200), 1);
        check("ovw_first_data", 32'(avg_data), 32'h1003);
        check("ovw_first_ovr", 32'(overrun), 0);
        k = 0;
        while (!overrun && k < 1200) begin tick1(); k++; end
        enable = 1'b0;
        check("ovw_second_wait", 32'(k < 1200), 1);
        check("ovw_second_data", 32'(avg_data), 32'h100B);
        check("ovw_valid_held", 32'(avg_valid), 1);
        avg_ready = 1'b1;
        tick1();
        check("ovw_valid_clear", 32'(avg_valid), 0);
        check("ovw_one_xfer", vcount - v_mark, 1);
        settle();

        // Reset during WAIT_DONE, then a late done must not be accumulated.
        rd_hang = 1'b1;
        enable = 1'b1;
        k = 0;
        while (!adc_start && k < 300) begin tick1(); k++; end
        check("rst_mid_wait", 32'(k < 300), 1);
        repeat (2) tick1();
        rst_n = 1'b0;
        repeat (2) tick1();
        rst_n = 1'b1;
        tick1();
        man_data = 16'hABCD; man_done = 1'b1;
        tick1();
        man_done = 1'b0;
        repeat (2) tick1();
        check("rst_mid_start", 32'(adc_start), 0);
        check("rst_mid_data", 32'(avg_data), 0);
        check("rst_mid_valid", 32'(avg_valid), 0);
        check("rst_mid_overrun", 32'(overrun), 0);
        check("rst_mid_timeout", 32'(timeout), 0);
        rd_hang = 1'b0;
        rd_base = 16'h0010; rd_step = 16'h0010; rd_mark = n_done;
        v_mark = vcount;
        k = 0;
        while (vcount == v_mark && k < 1500) begin tick1(); k++; end
        enable = 1'b0;
        check("rst_post_wait", 32'(k < 1500), 1);
        check("rst_post_avg", 32'(vdata), 32'h0048);
        settle();

        // Single-sample averaging on the LOG2_AVG=0 instance.
        rd_base = 16'hFFFF; rd_step = 16'h0000; rd_mark = n_done;
        v_mark = v0count;
        enable0 = 1'b1;
        k = 0;
        while (v0count == v_mark && k < 300) begin tick1(); k++; end
        enable0 = 1'b0;
        check("l0_wait", 32'(k < 300), 1);
        check("l0_data", 32'(v0data), 32'hFFFF);
        check("l0_latency", v0cyc - done_cyc, 2);
        check("l0_overrun", 32'(overrun0), 0);
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
